// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the March C- memory BIST controller.
//   - state_t          : controller FSM states
//   - ELEM_COUNT/LAST  : number of March elements and index of the final one
//   - ELEM_* tables    : per-element properties, one bit per element index
//                        (bit i describes element Ei; unused upper bits are 0)
//   - BG0_FILL/BG1_FILL: fill bit of the all-zeros / all-ones backgrounds;
//                        replicated to the data width by the users
// -----------------------------------------------------------------------------
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int ELEM_W     = 3;
    localparam int ELEM_COUNT = 6;
    localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(ELEM_COUNT - 1);

    // March C-:
    //   E0 up   w0        E1 up   r0 w1     E2 up   r1 w0
    //   E3 down r0 w1     E4 down r1 w0     E5 down r0
    // Tables are 2^ELEM_W wide so any element index selects a defined bit.
    localparam logic [7:0] ELEM_DOWN      = 8'b0011_1000;
    localparam logic [7:0] ELEM_HAS_READ  = 8'b0011_1110;
    localparam logic [7:0] ELEM_HAS_WRITE = 8'b0001_1111;
    localparam logic [7:0] ELEM_RD_POL    = 8'b0001_0100;
    localparam logic [7:0] ELEM_WR_POL    = 8'b0000_1010;

    // Background fill bits: B0 = all zeros, B1 = all ones.
    localparam logic BG0_FILL = 1'b0;
    localparam logic BG1_FILL = 1'b1;

    // Maps a polarity bit from the tables onto the matching background fill.
    function automatic logic bg_fill(input logic pol);
        return pol ? BG1_FILL : BG0_FILL;
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// -----------------------------------------------------------------------------
// bist_addr_gen
// Up/down address counter for the March sequencer.
//   clk, rst   : clock, synchronous active-high reset (address returns to 0)
//   load       : load the start address of an element
//   load_down  : direction of the element being loaded (1 -> N-1, 0 -> 0)
//   step       : advance one address in the current direction
//   down       : direction of the element currently running
//   addr       : current address
//   terminal   : current address is the last one of the running element
// The counter saturates at the terminal address so an element can never
// wrap into a second pass; the sequencer reloads it for the next element.
// -----------------------------------------------------------------------------
module bist_addr_gen #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              terminal
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_next;

    assign terminal = down ? (addr_reg == '0) : (addr_reg == '1);
    assign addr     = addr_reg;

    always_comb begin
        addr_next = addr_reg;
        if (load) begin
            addr_next = load_down ? '1 : '0;
        end else if (step && !terminal) begin
            addr_next = down ? (addr_reg - ADDR_ONE) : (addr_reg + ADDR_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= '0;
        end else begin
            addr_reg <= addr_next;
        end
    end

endmodule

// File: rtl/bist_controller.sv
// -----------------------------------------------------------------------------
// bist_controller
// March C- BIST sequencer for a 2^ADDR_W x DATA_W memory with an external
// comparator.
//   clk, rst   : clock, synchronous active-high reset (aborts any run)
//   start      : one-cycle run request; accepted only in IDLE or DONE
//   mem_addr   : memory address
//   mem_wdata  : memory write data
//   mem_we     : memory write strobe
//   mem_re     : memory read strobe (read data valid the following cycle)
//   data_et    : expected read data for the external comparator
//   read_en    : comparator enable, high in the cycle after each read
//   error      : comparator mismatch, sampled while read_en is high
//   busy       : run in progress (WR, RD, DRAIN)
//   done       : run finished; held until the next accepted start or rst
//   fail       : sticky mismatch flag for the current/last run
//   fail_addr  : address of the first mismatching read
//   fail_elem  : March element index of the first mismatching read
// One memory operation is issued per cycle. A read is compared one cycle
// later, overlapping the next operation; DRAIN covers the compare of the very
// last read. done is registered one cycle after DONE is entered, so it rises
// 10N+2 cycles after the start edge with fail already settled.
// -----------------------------------------------------------------------------
module bist_controller
    import bist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] data_et,
    output logic              read_en,
    input  logic              error,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    state_t              state_reg;
    state_t              state_next;
    logic [ELEM_W-1:0]   elem_reg;
    logic [ELEM_W-1:0]   elem_next;
    logic [ELEM_W-1:0]   nxt_idx;

    // Compare-stage registers: describe the read issued in the previous cycle.
    logic                read_en_reg;
    logic [DATA_W-1:0]   data_et_reg;
    logic [ADDR_W-1:0]   cmp_addr_reg;
    logic [ELEM_W-1:0]   cmp_elem_reg;

    logic                done_reg;
    logic                fail_reg;
    logic [ADDR_W-1:0]   fail_addr_reg;
    logic [ELEM_W-1:0]   fail_elem_reg;

    logic                start_accept;
    logic                end_element;

    logic                ag_load;
    logic                ag_load_down;
    logic                ag_step;
    logic [ADDR_W-1:0]   ag_addr;
    logic                ag_terminal;

    // Properties of the running element and of the one that follows it.
    logic                cur_down;
    logic                cur_has_write;
    logic                cur_rd_fill;
    logic                cur_wr_fill;
    logic                nxt_down;
    logic                nxt_has_read;
    logic [DATA_W-1:0]   rd_pattern;
    logic [DATA_W-1:0]   wr_pattern;

    assign nxt_idx       = elem_reg + ELEM_W'(1);
    assign cur_down      = ELEM_DOWN[elem_reg];
    assign cur_has_write = ELEM_HAS_WRITE[elem_reg];
    assign cur_rd_fill   = bg_fill(ELEM_RD_POL[elem_reg]);
    assign cur_wr_fill   = bg_fill(ELEM_WR_POL[elem_reg]);
    assign nxt_down      = ELEM_DOWN[nxt_idx];
    assign nxt_has_read  = ELEM_HAS_READ[nxt_idx];

    // Backgrounds are uniform, so every data bit carries the fill bit.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pattern
            assign rd_pattern[gi] = cur_rd_fill;
            assign wr_pattern[gi] = cur_wr_fill;
        end
    endgenerate

    bist_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (cur_down),
        .addr      (ag_addr),
        .terminal  (ag_terminal)
    );

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            elem_reg  <= '0;
        end else begin
            state_reg <= state_next;
            elem_reg  <= elem_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and address-generator control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        elem_next    = elem_reg;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        start_accept = 1'b0;
        end_element  = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_accept = 1'b1;
                    elem_next    = '0;
                    ag_load      = 1'b1;
                    ag_load_down = ELEM_DOWN[0];
                    state_next   = ST_WR;
                end
            end
            ST_RD: begin
                // Read-then-write elements write the same address next cycle;
                // the read-only element walks on or finishes here.
                if (cur_has_write) begin
                    state_next = ST_WR;
                end else if (!ag_terminal) begin
                    ag_step = 1'b1;
                end else begin
                    end_element = 1'b1;
                end
            end
            ST_WR: begin
                if (!ag_terminal) begin
                    ag_step    = 1'b1;
                    state_next = ELEM_HAS_READ[elem_reg] ? ST_RD : ST_WR;
                end else begin
                    end_element = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (end_element) begin
            if (elem_reg == ELEM_LAST) begin
                state_next = ST_DRAIN;
            end else begin
                elem_next    = nxt_idx;
                ag_load      = 1'b1;
                ag_load_down = nxt_down;
                state_next   = nxt_has_read ? ST_RD : ST_WR;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Compare stage and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            read_en_reg   <= 1'b0;
            data_et_reg   <= '0;
            cmp_addr_reg  <= '0;
            cmp_elem_reg  <= '0;
            done_reg      <= 1'b0;
            fail_reg      <= 1'b0;
            fail_addr_reg <= '0;
            fail_elem_reg <= '0;
        end else begin
            read_en_reg  <= (state_reg == ST_RD);
            data_et_reg  <= (state_reg == ST_RD) ? rd_pattern : '0;
            cmp_addr_reg <= (state_reg == ST_RD) ? ag_addr : '0;
            cmp_elem_reg <= (state_reg == ST_RD) ? elem_reg : '0;

            if (start_accept) begin
                done_reg      <= 1'b0;
                fail_reg      <= 1'b0;
                fail_addr_reg <= '0;
                fail_elem_reg <= '0;
            end else begin
                if (state_reg == ST_DONE) begin
                    done_reg <= 1'b1;
                end
                // Only the first mismatch of a run is recorded.
                if (read_en_reg && error && !fail_reg) begin
                    fail_reg      <= 1'b1;
                    fail_addr_reg <= cmp_addr_reg;
                    fail_elem_reg <= cmp_elem_reg;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_we    = (state_reg == ST_WR);
    assign mem_re    = (state_reg == ST_RD);
    assign mem_addr  = (mem_we || mem_re) ? ag_addr : '0;
    assign mem_wdata = mem_we ? wr_pattern : '0;
    assign data_et   = data_et_reg;
    assign read_en   = read_en_reg;
    assign busy      = (state_reg == ST_WR) || (state_reg == ST_RD) ||
                       (state_reg == ST_DRAIN);
    assign done      = done_reg;
    assign fail      = fail_reg;
    assign fail_addr = fail_addr_reg;
    assign fail_elem = fail_elem_reg;

endmodule

// File: tb/tb_bist_controller.sv
// -----------------------------------------------------------------------------
// tb_bist_controller
// Drives bist_controller against a 16x8 behavioural memory with optional
// stuck-at and write-disable faults and an external comparator. Each accepted
// start pushes the full March C- operation list, the expected data_et list and
// the expected run result into queues; a monitor pops and compares them as the
// DUT issues operations, enables compares and raises done.
// -----------------------------------------------------------------------------
module tb_bist_controller;
    import bist_pkg::*;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 4;
    localparam int N          = 16;
    localparam int RUN_CYCLES = 10 * N + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] data_et;
    logic              read_en;
    logic              error;
    logic              busy;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;

    always #5 clk = ~clk;

    bist_controller #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .data_et   (data_et),
        .read_en   (read_en),
        .error     (error),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    // ---------------- behavioural memory with fault injection ----------------
    logic [DATA_W-1:0] mem [N];
    logic [DATA_W-1:0] rdata = '0;
    logic              mem_clear = 1'b0;
    logic              sa_en = 1'b0;
    logic [ADDR_W-1:0] sa_addr = '0;
    logic [DATA_W-1:0] sa_mask = '0;
    logic              wd_en = 1'b0;
    logic [ADDR_W-1:0] wd_addr = '0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (mem_we && !(wd_en && mem_addr == wd_addr)) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_re) begin
            rdata <= mem[mem_addr] | ((sa_en && mem_addr == sa_addr) ? sa_mask : '0);
        end
    end

    assign error = read_en && (rdata != data_et);

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    typedef struct {
        int                cycles;
        logic              fail;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        elem;
    } res_t;

    op_t               op_q[$];
    logic [DATA_W-1:0] et_q[$];
    res_t              res_q[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_w(input int a, input logic [DATA_W-1:0] d);
        op_t e;
        e.we = 1'b1; e.addr = ADDR_W'(a); e.data = d;
        op_q.push_back(e);
    endtask

    task automatic push_r(input int a, input logic [DATA_W-1:0] d);
        op_t e;
        e.we = 1'b0; e.addr = ADDR_W'(a); e.data = d;
        op_q.push_back(e);
        et_q.push_back(d);
    endtask

    // March C-, written out element by element.
    task automatic push_march();
        for (int a = 0; a < N; a++) push_w(a, 8'h00);
        for (int a = 0; a < N; a++) begin push_r(a, 8'h00); push_w(a, 8'hFF); end
        for (int a = 0; a < N; a++) begin push_r(a, 8'hFF); push_w(a, 8'h00); end
        for (int a = N - 1; a >= 0; a--) begin push_r(a, 8'h00); push_w(a, 8'hFF); end
        for (int a = N - 1; a >= 0; a--) begin push_r(a, 8'hFF); push_w(a, 8'h00); end
        for (int a = N - 1; a >= 0; a--) push_r(a, 8'h00);
    endtask

    // ---------------- monitor ----------------
    logic done_prev = 1'b0;
    op_t  mon_op;
    res_t mon_res;

    always @(posedge clk) begin
        #1;
        check_eq("we_re_exclusive", mem_we & mem_re, 0);
        check_eq("read_en_when_idle", read_en & ~busy, 0);
        if (mem_we || mem_re) begin
            check_eq("op_expected", op_q.size() != 0, 1);
            if (op_q.size() != 0) begin
                mon_op = op_q.pop_front();
                check_eq("op_kind", {mem_we, mem_re}, {mon_op.we, ~mon_op.we});
                check_eq("op_addr", mem_addr, mon_op.addr);
                if (mon_op.we) check_eq("op_wdata", mem_wdata, mon_op.data);
            end
        end
        if (read_en) begin
            check_eq("compare_expected", et_q.size() != 0, 1);
            if (et_q.size() != 0) check_eq("data_et", data_et, et_q.pop_front());
        end
        if (done && !done_prev) begin
            check_eq("result_expected", res_q.size() != 0, 1);
            if (res_q.size() != 0) begin
                mon_res = res_q.pop_front();
                $display("run done: cycles=%0d fail=%0d fail_addr=%0d fail_elem=%0d",
                         cyc - start_cyc, fail, fail_addr, fail_elem);
                check_eq("done_cycle", cyc - start_cyc, mon_res.cycles);
                check_eq("fail_flag", fail, mon_res.fail);
                check_eq("fail_addr", fail_addr, mon_res.addr);
                check_eq("fail_elem", fail_elem, mon_res.elem);
                check_eq("busy_at_done", busy, 0);
            end
        end
        done_prev = done;
    end

    // ---------------- stimulus ----------------
    function automatic logic [63:0] out_vec();
        return {31'd0, mem_addr, mem_wdata, mem_we, mem_re, data_et, read_en,
                busy, done, fail, fail_addr, fail_elem};
    endfunction

    // Called at #1 after an edge; leaves time at #1 after the start edge.
    task automatic start_run(input logic exp_fail, input int fa, input int fe);
        res_t r;
        r.cycles = RUN_CYCLES; r.fail = exp_fail;
        r.addr = ADDR_W'(fa); r.elem = 3'(fe);
        push_march();
        res_q.push_back(r);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
        $display("start accepted at cycle %0d (expect fail=%0d addr=%0d elem=%0d)",
                 start_cyc, exp_fail, fa, fe);
        check_eq("start_clears_result", {done, fail, fail_addr, fail_elem}, 0);
        check_eq("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < RUN_CYCLES + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("done_within_budget", done, 1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("done_held", {done, busy}, 2'b10);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", out_vec(), 0);
        check_eq("reset_state", dut.state_reg, ST_IDLE);
        rst = 1'b0;
        mem_clear = 1'b1;
        @(posedge clk);
        #1;
        mem_clear = 1'b0;

        // V1: fault-free run
        start_run(1'b0, 0, 0);
        wait_done();

        // V2: bit 3 of address 5 stuck-at-1
        sa_en = 1'b1; sa_addr = 4'd5; sa_mask = 8'h08;
        start_run(1'b1, 5, 1);
        wait_done();

        // V6: restart after a failing run with the fault removed
        sa_en = 1'b0;
        start_run(1'b0, 0, 0);
        wait_done();

        // V3: address 15 write-disabled, preloaded with 0x00
        mem_clear = 1'b1;
        @(posedge clk);
        #1;
        mem_clear = 1'b0;
        wd_en = 1'b1; wd_addr = 4'd15;
        start_run(1'b1, 15, 2);
        wait_done();
        wd_en = 1'b0;

        // V4: start pulsed again at cycle 50 is ignored
        start_run(1'b0, 0, 0);
        repeat (49) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("restart_ignored_busy", busy, 1);
        wait_done();

        // V5: rst at cycle 80 aborts the run
        start_run(1'b0, 0, 0);
        repeat (79) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #2;
        op_q.delete();
        et_q.delete();
        res_q.delete();
        check_eq("abort_outputs", out_vec(), 0);
        check_eq("abort_state", dut.state_reg, ST_IDLE);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_no_done", {done, busy}, 0);
        start_run(1'b0, 0, 0);
        wait_done();

        check_eq("op_queue_drained", op_q.size(), 0);
        check_eq("et_queue_drained", et_q.size(), 0);
        check_eq("result_queue_drained", res_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
